count_seq_checker: RTL and testbench
====================================

// Module: count_seq_checker
// PURPOSE
//   Receive-side monitor for the synchronous up/down counters. Samples a counter's q output
//   and direction each enabled cycle, checks every step against the expected +/-1 mod 2^WIDTH
//   sequence, locks after a run of good steps, and reports sequence errors and wrap events.
//   Sits beside any counter instance, on-chip or in bench, as a self-check block.
// PARAMETERS
//   WIDTH     4   counter width checked; the arithmetic is mod 2^WIDTH
//   LOCK_CNT  2   consecutive matching steps needed to enter LOCKED (>=1)
//   ERR_W     8   width of err_count and wrap_count (saturating)
// PORTS
//   clk         in   1        clock, all state updates on rising edge
//   rst         in   1        synchronous reset, active-high
//   en          in   1        sample strobe: q_in/up are valid this cycle
//   q_in        in   WIDTH    observed counter value
//   up          in   1        direction applied to q_in to form the next value (1 = up, 0 = down)
//   locked      out  1        1 while the FSM is in LOCKED
//   expected    out  WIDTH    predicted next q_in (prev +/- 1 per stored up)
//   err_pulse   out  1        one-cycle flag: mismatch seen while LOCKED
//   wrap_pulse  out  1        one-cycle flag: legal wrap (max->0 up, 0->max down) while LOCKED
//   err_count   out  ERR_W    number of errors, saturates at 2^ERR_W-1
//   wrap_count  out  ERR_W    number of wraps, saturates at 2^ERR_W-1
// BEHAVIOUR
//   - Reset (clk edge with rst=1): state IDLE; prev, up_d, good_cnt, expected, err_count and
//     wrap_count all 0; locked, err_pulse and wrap_pulse all 0. rst overrides en.
//   - All outputs are registered. A pulse is high for exactly the cycle after the edge that
//     sampled the q_in causing it. Pulses are 0 in every other cycle, including en=0 cycles.
//   - en=0: all state, counters, locked and expected hold their values.
//   - On every enabled edge: prev<=q_in and up_d<=up. expected<=up ? q_in+1 : q_in-1, truncated
//     to WIDTH bits. match := (q_in == expected held before that edge).
//   - FSM states IDLE, ACQ, LOCKED:
//       IDLE   : en -> ACQ, good_cnt<=0. No comparison is made.
//       ACQ    : en & match -> good_cnt+1; reaching LOCK_CNT -> LOCKED, locked<=1, good_cnt<=0.
//                en & ~match -> good_cnt<=0, stay in ACQ, no error flagged (the block resyncs to q_in).
//       LOCKED : en & match -> stay; if (up_d & prev==2^WIDTH-1 & q_in==0) or
//                (~up_d & prev==0 & q_in==2^WIDTH-1) -> wrap_pulse<=1, wrap_count+1 (saturating).
//                en & ~match -> err_pulse<=1, err_count+1 (saturating), locked<=0, ACQ, good_cnt<=0.
//   - A direction change is legal at any sample. The up sampled with q_k alone defines the
//     expected q_(k+1).
//   - Counters saturate and never wrap back to 0. Only rst clears them.
//   - Reset in any state, LOCKED included, returns to IDLE. The first sample after reset
//     never raises an error.
// TESTING (defaults WIDTH=4, LOCK_CNT=2 unless stated)
//   1 rst, then en=1 up=1 q_in=0,1,2 -> locked=1 after the edge sampling 2; err_count=0; expected=3.
//   2 locked, up=1, q_in=14,15,0,1 -> wrap_pulse=1 for one cycle after 0 is sampled;
//     wrap_count=1; err_pulse stays 0.
//   3 locked, up=1, q_in=5,6,9 -> err_pulse for one cycle, err_count=1, locked=0;
//     then 10,11 -> locked=1 again, err_count still 1.
//   4 locked, q_in=7(up=1), 8(up=0), 7(up=0), 6 -> no error; 0(up=0) after 1 gives no wrap,
//     15 after 0(up=0) gives wrap_pulse.
//   5 en toggled 1,0,0,1 between consecutive valid values -> identical result to the back-to-back case;
//     outputs hold during en=0.
//   6 ERR_W=2: inject 5 errors (relock between them) -> err_count=3 saturated;
//     rst mid-LOCKED -> all outputs 0 next cycle; first sample after reset does not raise err_pulse.

Source files
------------

// File: rtl/count_seq_checker_if.sv
// Sample bundle between a counter under observation and its sequence checker.
// master = the side presenting samples, slave = the checker.
interface count_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             en;
  logic [WIDTH-1:0] q_in;
  logic             up;
  logic             locked;
  logic [WIDTH-1:0] expected;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;

  modport master (
    output en, q_in, up,
    input  locked, expected, err_pulse, wrap_pulse, err_count, wrap_count
  );

  modport slave (
    input  en, q_in, up,
    output locked, expected, err_pulse, wrap_pulse, err_count, wrap_count
  );
endinterface

// File: rtl/count_seq_checker.sv
// Up/down counter sequence monitor: predicts q_in +/- 1 mod 2^WIDTH, locks after
// LOCK_CNT good steps, flags mismatches and legal wraps while locked.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  count_seq_checker_if.slave mon
);
  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] QMAX = '1;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx;
  logic             up_d, up_d_nx;
  logic [GW-1:0]    good_cnt, good_cnt_nx;
  logic [WIDTH-1:0] expected, expected_nx;
  logic [ERR_W-1:0] err_count, err_count_nx;
  logic [ERR_W-1:0] wrap_count, wrap_count_nx;
  logic             locked, locked_nx;
  logic             err_pulse, err_pulse_nx;
  logic             wrap_pulse, wrap_pulse_nx;

  logic match, wrap_hit;

  assign match    = (mon.q_in == expected);
  // Wrap is judged from the previous sample and its direction, not from expected.
  assign wrap_hit = ( up_d && (prev == QMAX) && (mon.q_in == '0)) ||
                    (!up_d && (prev == '0)   && (mon.q_in == QMAX));

  always_comb begin
    state_nx      = state;
    prev_nx       = prev;
    up_d_nx       = up_d;
    good_cnt_nx   = good_cnt;
    expected_nx   = expected;
    err_count_nx  = err_count;
    wrap_count_nx = wrap_count;
    locked_nx     = locked;
    err_pulse_nx  = 1'b0;
    wrap_pulse_nx = 1'b0;

    if (mon.en) begin
      prev_nx     = mon.q_in;
      up_d_nx     = mon.up;
      expected_nx = mon.up ? mon.q_in + 1'b1 : mon.q_in - 1'b1;

      case (state)
        IDLE: begin
          state_nx    = ACQ;
          good_cnt_nx = '0;
        end
        ACQ: begin
          if (match) begin
            if (good_cnt == GW'(LOCK_CNT - 1)) begin
              state_nx    = LOCKED;
              locked_nx   = 1'b1;
              good_cnt_nx = '0;
            end else begin
              good_cnt_nx = good_cnt + 1'b1;
            end
          end else begin
            // Silent resync: expected already follows q_in.
            good_cnt_nx = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            if (wrap_hit) begin
              wrap_pulse_nx = 1'b1;
              if (wrap_count != '1) wrap_count_nx = wrap_count + 1'b1;
            end
          end else begin
            err_pulse_nx = 1'b1;
            if (err_count != '1) err_count_nx = err_count + 1'b1;
            locked_nx    = 1'b0;
            state_nx     = ACQ;
            good_cnt_nx  = '0;
          end
        end
        default: begin
          state_nx  = IDLE;
          locked_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      up_d       <= 1'b0;
      good_cnt   <= '0;
      expected   <= '0;
      err_count  <= '0;
      wrap_count <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      up_d       <= up_d_nx;
      good_cnt   <= good_cnt_nx;
      expected   <= expected_nx;
      err_count  <= err_count_nx;
      wrap_count <= wrap_count_nx;
      locked     <= locked_nx;
      err_pulse  <= err_pulse_nx;
      wrap_pulse <= wrap_pulse_nx;
    end
  end

  assign mon.locked     = locked;
  assign mon.expected   = expected;
  assign mon.err_pulse  = err_pulse;
  assign mon.wrap_pulse = wrap_pulse;
  assign mon.err_count  = err_count;
  assign mon.wrap_count = wrap_count;
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: default instance plus an ERR_W=2 instance
// fed identical samples for the saturation case.
module tb_count_seq_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(4), .ERR_W(8)) mif ();
  count_seq_checker_if #(.WIDTH(4), .ERR_W(2)) sif ();

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .mon(mif.slave));
  count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .mon(sif.slave));

  // Apply one sample to both instances, advance one edge, settle.
  task automatic drive(input logic e, input logic [3:0] q, input logic u);
    mif.en = e; mif.q_in = q; mif.up = u;
    sif.en = e; sif.q_in = q; sif.up = u;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 4'd5, 1'b1);
    drive(1'b1, 4'd6, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({mif.locked, mif.expected, mif.err_pulse, mif.wrap_pulse, mif.err_count, mif.wrap_count} !== '0) begin
      fails++; $display("FAIL reset_state got l=%0d e=%0d ep=%0d wp=%0d ec=%0d wc=%0d want all 0",
        mif.locked, mif.expected, mif.err_pulse, mif.wrap_pulse, mif.err_count, mif.wrap_count);
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(1'b1, 4'd0, 1'b1);
    drive(1'b1, 4'd1, 1'b1);
    tests++;
    if (mif.locked !== 1'b0) begin fails++; $display("FAIL lock_early got %0d want 0", mif.locked); end
    drive(1'b1, 4'd2, 1'b1);
    tests++;
    if (mif.locked !== 1'b1) begin fails++; $display("FAIL lock_locked got %0d want 1", mif.locked); end
    tests++;
    if (mif.expected !== 4'd3) begin fails++; $display("FAIL lock_expected got %0d want 3", mif.expected); end
    tests++;
    if (mif.err_count !== 8'd0) begin fails++; $display("FAIL lock_errcnt got %0d want 0", mif.err_count); end
  endtask

  task automatic test_wrap_up();
    do_reset();
    drive(1'b1, 4'd11, 1'b1);
    drive(1'b1, 4'd12, 1'b1);
    drive(1'b1, 4'd13, 1'b1);
    drive(1'b1, 4'd14, 1'b1);
    drive(1'b1, 4'd15, 1'b1);
    tests++;
    if (mif.wrap_pulse !== 1'b0) begin fails++; $display("FAIL wrapup_pre got %0d want 0", mif.wrap_pulse); end
    drive(1'b1, 4'd0, 1'b1);
    tests++;
    if (mif.wrap_pulse !== 1'b1) begin fails++; $display("FAIL wrapup_pulse got %0d want 1", mif.wrap_pulse); end
    tests++;
    if (mif.wrap_count !== 8'd1) begin fails++; $display("FAIL wrapup_count got %0d want 1", mif.wrap_count); end
    drive(1'b1, 4'd1, 1'b1);
    tests++;
    if (mif.wrap_pulse !== 1'b0) begin fails++; $display("FAIL wrapup_onecycle got %0d want 0", mif.wrap_pulse); end
    tests++;
    if ({mif.err_pulse, mif.err_count} !== 9'd0) begin
      fails++; $display("FAIL wrapup_noerr got ep=%0d ec=%0d want 0 0", mif.err_pulse, mif.err_count);
    end
  endtask

  // Continues from test_wrap_up: locked, expected = 2.
  task automatic test_error_relock();
    drive(1'b1, 4'd2, 1'b1);
    drive(1'b1, 4'd3, 1'b1);
    drive(1'b1, 4'd4, 1'b1);
    drive(1'b1, 4'd5, 1'b1);
    drive(1'b1, 4'd6, 1'b1);
    drive(1'b1, 4'd9, 1'b1);
    tests++;
    if (mif.err_pulse !== 1'b1) begin fails++; $display("FAIL err_pulse got %0d want 1", mif.err_pulse); end
    tests++;
    if (mif.err_count !== 8'd1) begin fails++; $display("FAIL err_count got %0d want 1", mif.err_count); end
    tests++;
    if (mif.locked !== 1'b0) begin fails++; $display("FAIL err_unlock got %0d want 0", mif.locked); end
    tests++;
    if (mif.expected !== 4'd10) begin fails++; $display("FAIL err_resync got %0d want 10", mif.expected); end
    drive(1'b1, 4'd10, 1'b1);
    tests++;
    if ({mif.err_pulse, mif.locked} !== 2'b00) begin
      fails++; $display("FAIL err_onecycle got ep=%0d l=%0d want 0 0", mif.err_pulse, mif.locked);
    end
    drive(1'b1, 4'd11, 1'b1);
    tests++;
    if (mif.locked !== 1'b1) begin fails++; $display("FAIL err_relock got %0d want 1", mif.locked); end
    tests++;
    if (mif.err_count !== 8'd1) begin fails++; $display("FAIL err_count_hold got %0d want 1", mif.err_count); end
  endtask

  task automatic test_direction();
    do_reset();
    drive(1'b1, 4'd4, 1'b1);
    drive(1'b1, 4'd5, 1'b1);
    drive(1'b1, 4'd6, 1'b1);
    drive(1'b1, 4'd7, 1'b1);
    drive(1'b1, 4'd8, 1'b0);
    drive(1'b1, 4'd7, 1'b0);
    drive(1'b1, 4'd6, 1'b0);
    tests++;
    if ({mif.locked, mif.err_count} !== {1'b1, 8'd0}) begin
      fails++; $display("FAIL dir_change got l=%0d ec=%0d want 1 0", mif.locked, mif.err_count);
    end
    for (int v = 5; v >= 0; v--) drive(1'b1, 4'(v), 1'b0);
    tests++;
    if ({mif.wrap_pulse, mif.err_pulse} !== 2'b00) begin
      fails++; $display("FAIL dir_nowrap got wp=%0d ep=%0d want 0 0", mif.wrap_pulse, mif.err_pulse);
    end
    drive(1'b1, 4'd15, 1'b0);
    tests++;
    if (mif.wrap_pulse !== 1'b1) begin fails++; $display("FAIL dir_wrapdown got %0d want 1", mif.wrap_pulse); end
    tests++;
    if (mif.wrap_count !== 8'd1) begin fails++; $display("FAIL dir_wrapcount got %0d want 1", mif.wrap_count); end
  endtask

  task automatic test_en_gaps();
    do_reset();
    drive(1'b1, 4'd0, 1'b1);
    drive(1'b0, 4'd9, 1'b0);
    drive(1'b0, 4'd7, 1'b0);
    tests++;
    if ({mif.expected, mif.locked} !== {4'd1, 1'b0}) begin
      fails++; $display("FAIL gap_hold got e=%0d l=%0d want 1 0", mif.expected, mif.locked);
    end
    drive(1'b1, 4'd1, 1'b1);
    drive(1'b0, 4'd12, 1'b1);
    drive(1'b0, 4'd3, 1'b0);
    drive(1'b1, 4'd2, 1'b1);
    tests++;
    if ({mif.locked, mif.expected} !== {1'b1, 4'd3}) begin
      fails++; $display("FAIL gap_lock got l=%0d e=%0d want 1 3", mif.locked, mif.expected);
    end
    drive(1'b0, 4'd9, 1'b1);
    tests++;
    if ({mif.locked, mif.expected, mif.err_pulse, mif.err_count} !== {1'b1, 4'd3, 1'b0, 8'd0}) begin
      fails++; $display("FAIL gap_locked_hold got l=%0d e=%0d ep=%0d ec=%0d want 1 3 0 0",
        mif.locked, mif.expected, mif.err_pulse, mif.err_count);
    end
    drive(1'b1, 4'd8, 1'b1);
    drive(1'b0, 4'd8, 1'b1);
    tests++;
    if ({mif.err_pulse, mif.err_count} !== {1'b0, 8'd1}) begin
      fails++; $display("FAIL gap_pulse_drop got ep=%0d ec=%0d want 0 1", mif.err_pulse, mif.err_count);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [3:0] e;
    do_reset();
    drive(1'b1, 4'd0, 1'b1);
    drive(1'b1, 4'd1, 1'b1);
    drive(1'b1, 4'd2, 1'b1);
    e = 4'd3;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, e + 4'd5, 1'b1);
      tests++;
      if (sif.err_pulse !== 1'b1) begin fails++; $display("FAIL sat_pulse%0d got %0d want 1", k, sif.err_pulse); end
      e = e + 4'd6;
      drive(1'b1, e, 1'b1);
      e = e + 4'd1;
      drive(1'b1, e, 1'b1);
      e = e + 4'd1;
    end
    tests++;
    if (sif.err_count !== 2'd3) begin fails++; $display("FAIL sat_count got %0d want 3", sif.err_count); end
    tests++;
    if (mif.err_count !== 8'd5) begin fails++; $display("FAIL sat_wide_count got %0d want 5", mif.err_count); end
    tests++;
    if (sif.locked !== 1'b1) begin fails++; $display("FAIL sat_relocked got %0d want 1", sif.locked); end
    rst = 1'b1;
    drive(1'b1, e, 1'b1);
    rst = 1'b0;
    tests++;
    if ({sif.locked, sif.expected, sif.err_pulse, sif.wrap_pulse, sif.err_count, sif.wrap_count} !== '0) begin
      fails++; $display("FAIL rst_locked got l=%0d e=%0d ep=%0d wp=%0d ec=%0d wc=%0d want all 0",
        sif.locked, sif.expected, sif.err_pulse, sif.wrap_pulse, sif.err_count, sif.wrap_count);
    end
    drive(1'b1, 4'd9, 1'b1);
    tests++;
    if ({sif.err_pulse, sif.locked, sif.expected} !== {1'b0, 1'b0, 4'd10}) begin
      fails++; $display("FAIL rst_first got ep=%0d l=%0d e=%0d want 0 0 10", sif.err_pulse, sif.locked, sif.expected);
    end
    drive(1'b1, 4'd3, 1'b1);
    tests++;
    if ({sif.err_pulse, sif.err_count} !== {1'b0, 2'd0}) begin
      fails++; $display("FAIL rst_acq_mismatch got ep=%0d ec=%0d want 0 0", sif.err_pulse, sif.err_count);
    end
  endtask

  initial begin
    mif.en = 1'b0; mif.q_in = '0; mif.up = 1'b0;
    sif.en = 1'b0; sif.q_in = '0; sif.up = 1'b0;
    test_reset();
    test_lock();
    test_wrap_up();
    test_error_relock();
    test_direction();
    test_en_gaps();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
